// File: rtl/can_ctrl_pkg.sv
// Shared types and constants for the CAN transmit control path.
package can_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUS,
    START,
    TX_BUSY
  } sched_state_t;

  // Width of each per-mailbox retry counter
  localparam int unsigned RETRY_W = 4;

  localparam int unsigned CAN_STD_ID_W = 11;
  localparam int unsigned CAN_EXT_ID_W = 29;

endpackage

// File: rtl/can_id_arbiter.sv
// Combinational CAN-ID arbiter: lowest ID wins, lowest index on a tie.
module can_id_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 11
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ID_W-1:0]    req_id,
  output logic [$clog2(NUM_REQ)-1:0] win_idx,
  output logic [ID_W-1:0]            win_id,
  output logic                       any_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Scan upward with a strict compare so equal IDs keep the lower index
  always_comb begin
    win_idx   = '0;
    win_id    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (!any_valid || (req_id[i*ID_W +: ID_W] < win_id))) begin
        any_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_id    = req_id[i*ID_W +: ID_W];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN frame transmitter among NUM_REQ mailboxes with
// ID-priority arbitration, per-mailbox retry counting and a TX watchdog.
module can_tx_scheduler
  import can_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = CAN_STD_ID_W,
  parameter int unsigned RETRY_MAX   = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       interframePeriod,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ID_W-1:0]    reqId,
  output logic                       txStart,
  output logic [$clog2(NUM_REQ)-1:0] txSel,
  output logic [ID_W-1:0]            txId,
  input  logic                       txDone,
  input  logic                       txArbLost,
  input  logic                       txError,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         fail,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_SAT  = '1;

  sched_state_t state_q, state_d;
  logic [IDX_W-1:0]   txSel_q, txSel_d;
  logic [ID_W-1:0]    txId_q, txId_d;
  logic               txStart_q, txStart_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] fail_q, fail_d;
  logic               busy_q, busy_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic [RETRY_W-1:0] retry_q [NUM_REQ];
  logic [RETRY_W-1:0] retry_d [NUM_REQ];
  logic [RETRY_W-1:0] retry_inc;

  logic [IDX_W-1:0] win_idx;
  logic [ID_W-1:0]  win_id;
  logic             any_valid;

  can_id_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req      (req),
    .req_id   (reqId),
    .win_idx  (win_idx),
    .win_id   (win_id),
    .any_valid(any_valid)
  );

  // Next-state, retry bookkeeping and registered-output computation
  always_comb begin
    state_d   = state_q;
    txSel_d   = txSel_q;
    txId_d    = txId_q;
    txStart_d = 1'b0;
    ack_d     = '0;
    fail_d    = '0;
    wdog_d    = wdog_q;
    retry_d   = retry_q;
    retry_inc = '0;

    // A withdrawn requester starts over with a clean retry count
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!req[i]) retry_d[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (|req) state_d = WAIT_BUS;
      end
      WAIT_BUS: begin
        if (!any_valid) begin
          state_d = IDLE;
        end else if (interframePeriod) begin
          txSel_d = win_idx;
          txId_d  = win_id;
          state_d = START;
        end
      end
      START: begin
        txStart_d = 1'b1;
        wdog_d    = '0;
        state_d   = TX_BUSY;
      end
      TX_BUSY: begin
        if (wdog_q != WD_SAT) wdog_d = wdog_q + 1'b1;
        // The frame in flight is resolved even if its requester let go;
        // the event update for txSel overrides the withdrawal clear above.
        if (txDone) begin
          ack_d[txSel_q]   = 1'b1;
          retry_d[txSel_q] = '0;
          state_d          = IDLE;
        end else if (txError || txArbLost || (wdog_q == WD_LAST)) begin
          retry_inc = retry_q[txSel_q] + 1'b1;
          if (retry_inc == RETRY_W'(RETRY_MAX)) begin
            fail_d[txSel_q]  = 1'b1;
            retry_d[txSel_q] = '0;
            state_d          = IDLE;
          end else begin
            retry_d[txSel_q] = retry_inc;
            state_d          = WAIT_BUS;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == START) || (state_d == TX_BUSY);
  end

  // Scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      txSel_q   <= '0;
      txId_q    <= '0;
      txStart_q <= 1'b0;
      ack_q     <= '0;
      fail_q    <= '0;
      busy_q    <= 1'b0;
      wdog_q    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) retry_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      txSel_q   <= txSel_d;
      txId_q    <= txId_d;
      txStart_q <= txStart_d;
      ack_q     <= ack_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      wdog_q    <= wdog_d;
      retry_q   <= retry_d;
    end
  end

  assign txStart = txStart_q;
  assign txSel   = txSel_q;
  assign txId    = txId_q;
  assign ack     = ack_q;
  assign fail    = fail_q;
  assign busy    = busy_q;

endmodule
